// File: rtl/axi4lite_reg_slave.sv
// ---------------------------------------------------------------------------
// axi4lite_reg_slave
//
// AXI4-Lite slave with four 32-bit read/write control registers. The
// register contents are driven out to user logic on slv_reg0..slv_reg3.
// Write address and write data are accepted independently and held until
// both have arrived. The write is then committed with byte strobes honoured.
// All responses are OKAY.
//
// Ports:
//   S_AXI_ACLK             clock, all logic on its rising edge
//   S_AXI_ARESET           asynchronous active-high reset
//   S_AXI_AW*              write-address channel (AWPROT ignored)
//   S_AXI_W*               write-data channel with byte strobes
//   S_AXI_B*               write-response channel (BRESP always OKAY)
//   S_AXI_AR*              read-address channel (ARPROT ignored)
//   S_AXI_R*               read-data channel (RRESP always OKAY)
//   slv_reg0..slv_reg3     current register contents
//   reg_wr_pulse[3:0]      bit n pulses for one cycle after register n is written
// ---------------------------------------------------------------------------
module axi4lite_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg0,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg1,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg2,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   slv_reg3,
  output logic [3:0]                      reg_wr_pulse
);

  localparam int NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

  logic                          aw_held;
  logic                          w_held;
  logic [1:0]                    aw_addr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [NUM_BYTES-1:0]          wstrb_q;
  logic                          bvalid;

  logic                          rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata;

  logic                          aw_hs;
  logic                          w_hs;
  logic                          ar_hs;
  logic                          commit;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // READY outputs come only from registered state, never from the VALID or
  // READY inputs. While a response is pending, no new write is accepted.
  assign S_AXI_AWREADY = !aw_held && !bvalid;
  assign S_AXI_WREADY  = !w_held && !bvalid;
  assign S_AXI_ARREADY = !rvalid;

  assign S_AXI_BVALID = bvalid;
  assign S_AXI_BRESP  = 2'b00;
  assign S_AXI_RVALID = rvalid;
  assign S_AXI_RDATA  = rdata;
  assign S_AXI_RRESP  = 2'b00;

  assign slv_reg0 = regs[0];
  assign slv_reg1 = regs[1];
  assign slv_reg2 = regs[2];
  assign slv_reg3 = regs[3];

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  // Both halves held means the write commits on this edge. The READYs are
  // low while held, so no new handshake can coincide with a commit.
  assign commit = aw_held && w_held;

  // Write channel control: capture each half independently, then commit and
  // raise BVALID until the master accepts the response.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= 2'b00;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid    <= 1'b0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bvalid  <= 1'b1;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= S_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (bvalid && S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Register storage. Only strobed bytes change, and an all-zero strobe
  // still counts as a write for the pulse. The pulse is registered, so it
  // lines up with the rising edge of BVALID.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      for (int n = 0; n < 4; n++) begin
        regs[n] <= '0;
      end
      reg_wr_pulse <= 4'b0000;
    end else begin
      reg_wr_pulse <= commit ? (4'b0001 << aw_addr_q) : 4'b0000;
      if (commit) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (wstrb_q[b]) begin
            regs[aw_addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end
      end
    end
  end

  // Read channel: data is sampled on the address handshake edge. A commit on
  // that same edge is not yet visible, so the read returns the old value.
  // RDATA keeps its last value after the response is accepted.
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= regs[S_AXI_ARADDR[3:2]];
    end else if (rvalid && S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_axi4lite_reg_slave
//
// Directed bench for axi4lite_reg_slave. Stimulus tasks push the expected
// BRESP, reg_wr_pulse and read data into queues. A monitor process pops and
// compares these whenever the DUT completes a response. Cycle-level
// properties are compared directly in the stimulus sequences: reset values,
// READY behaviour, write latency and backpressure stability.
// ---------------------------------------------------------------------------
module tb_axi4lite_reg_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] slv_reg0;
  logic [31:0] slv_reg1;
  logic [31:0] slv_reg2;
  logic [31:0] slv_reg3;
  logic [3:0]  reg_wr_pulse;

  int vectors     = 0;
  int miscompares = 0;

  logic [1:0]  exp_b_q[$];
  logic [3:0]  exp_pulse_q[$];
  logic [33:0] exp_r_q[$];

  always #5 clk = ~clk;

  axi4lite_reg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .S_AXI_AWADDR (awaddr),
    .S_AXI_AWPROT (awprot),
    .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA  (wdata),
    .S_AXI_WSTRB  (wstrb),
    .S_AXI_WVALID (wvalid),
    .S_AXI_WREADY (wready),
    .S_AXI_BRESP  (bresp),
    .S_AXI_BVALID (bvalid),
    .S_AXI_BREADY (bready),
    .S_AXI_ARADDR (araddr),
    .S_AXI_ARPROT (arprot),
    .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA  (rdata),
    .S_AXI_RRESP  (rresp),
    .S_AXI_RVALID (rvalid),
    .S_AXI_RREADY (rready),
    .slv_reg0     (slv_reg0),
    .slv_reg1     (slv_reg1),
    .slv_reg2     (slv_reg2),
    .slv_reg3     (slv_reg3),
    .reg_wr_pulse (reg_wr_pulse)
  );

  // Single point where every comparison is counted and reported.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // A bounded wait that expired counts as a failed comparison.
  task automatic reportTimeout(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  // Drive every master-side input in one step.
  task automatic applyStimulus(input logic aw_v, input logic [3:0] aw_a,
                               input logic w_v, input logic [31:0] w_d,
                               input logic [3:0] w_s, input logic b_r,
                               input logic ar_v, input logic [3:0] ar_a,
                               input logic r_r);
    awvalid = aw_v;
    awaddr  = aw_a;
    wvalid  = w_v;
    wdata   = w_d;
    wstrb   = w_s;
    bready  = b_r;
    arvalid = ar_v;
    araddr  = ar_a;
    rready  = r_r;
  endtask

  // Full write with BREADY high. Called and returns at 1 ns after a rising edge.
  task automatic doWrite(input logic [3:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
    logic aw_done = 1'b0;
    logic w_done  = 1'b0;
    logic aw_now;
    logic w_now;
    logic got     = 1'b0;
    exp_b_q.push_back(2'b00);
    exp_pulse_q.push_back(4'b0001 << addr[3:2]);
    applyStimulus(1'b1, addr, 1'b1, data, strb, 1'b1, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      @(negedge clk);
      aw_now = awvalid && awready;
      w_now  = wvalid && wready;
      @(posedge clk);
      #1;
      if (aw_now) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_now)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    if (!(aw_done && w_done)) begin
      reportTimeout("write_handshake");
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bvalid) begin got = 1'b1; break; end
    end
    if (!got) reportTimeout("write_bvalid");
    @(posedge clk);
    #1;
  endtask

  // Full read with RREADY high. Called and returns at 1 ns after a rising edge.
  task automatic doRead(input logic [3:0] addr, input logic [31:0] expected);
    logic done = 1'b0;
    logic got  = 1'b0;
    exp_r_q.push_back({2'b00, expected});
    arvalid = 1'b1;
    araddr  = addr;
    rready  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      done = arvalid && arready;
      @(posedge clk);
      #1;
      if (done) begin arvalid = 1'b0; break; end
    end
    if (!done) begin
      reportTimeout("read_handshake");
      arvalid = 1'b0;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rvalid) begin got = 1'b1; break; end
    end
    if (!got) reportTimeout("read_rvalid");
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge. A response with its READY high at
  // this point completes on the next rising edge, so it is counted once.
  initial begin : monitor
    logic prev_bvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_bvalid = 1'b0;
      end else begin
        if (bvalid && !prev_bvalid) begin
          if (exp_pulse_q.size() == 0) checkOutput("bvalid_unexpected", 64'(bvalid), 64'h0);
          else checkOutput("reg_wr_pulse", 64'(reg_wr_pulse), 64'(exp_pulse_q.pop_front()));
        end else if (reg_wr_pulse != 4'b0000) begin
          checkOutput("reg_wr_pulse_stray", 64'(reg_wr_pulse), 64'h0);
        end
        if (bvalid && bready && exp_b_q.size() != 0) begin
          checkOutput("bresp", 64'(bresp), 64'(exp_b_q.pop_front()));
        end
        if (rvalid && rready) begin
          if (exp_r_q.size() == 0) checkOutput("rvalid_unexpected", 64'(rvalid), 64'h0);
          else checkOutput("rdata_rresp", 64'({rresp, rdata}), 64'(exp_r_q.pop_front()));
        end
        prev_bvalid = bvalid;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    awprot = 3'b000;
    arprot = 3'b000;
    applyStimulus(1'b0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1);
    rst = 1'b1;
    #200;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] reset state");
    @(negedge clk);
    checkOutput("reset_slv_reg0", 64'(slv_reg0), 64'h0);
    checkOutput("reset_slv_reg1", 64'(slv_reg1), 64'h0);
    checkOutput("reset_slv_reg2", 64'(slv_reg2), 64'h0);
    checkOutput("reset_slv_reg3", 64'(slv_reg3), 64'h0);
    checkOutput("reset_readies", 64'({awready, wready, arready}), 64'h7);
    checkOutput("reset_valids", 64'({bvalid, rvalid}), 64'h0);
    @(posedge clk);
    #1;
    doRead(4'h0, 32'h0000_0000);
    doRead(4'h4, 32'h0000_0000);
    doRead(4'h8, 32'h0000_0000);
    doRead(4'hC, 32'h0000_0000);

    $display("[TB] sequential write and readback");
    doWrite(4'h0, 32'h0000_0001, 4'hF);
    doWrite(4'h4, 32'h0000_0002, 4'hF);
    doWrite(4'h8, 32'h0000_0003, 4'hF);
    doWrite(4'hC, 32'h0000_0004, 4'hF);
    checkOutput("seq_slv_reg0", 64'(slv_reg0), 64'h1);
    checkOutput("seq_slv_reg3", 64'(slv_reg3), 64'h4);
    doRead(4'h0, 32'h0000_0001);
    doRead(4'h4, 32'h0000_0002);
    doRead(4'h8, 32'h0000_0003);
    doRead(4'hC, 32'h0000_0004);

    $display("[TB] byte strobes");
    doWrite(4'h8, 32'hAABB_CCDD, 4'hF);
    doWrite(4'h8, 32'h1122_3344, 4'h5);
    doRead(4'h8, 32'hAA22_CC44);
    doWrite(4'hB, 32'hFFFF_FFFF, 4'h0);
    doRead(4'h8, 32'hAA22_CC44);

    $display("[TB] decoupled channels");
    exp_b_q.push_back(2'b00);
    exp_pulse_q.push_back(4'b0010);
    applyStimulus(1'b1, 4'h4, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1);
    @(negedge clk);
    checkOutput("dec_awready_before", 64'(awready), 64'h1);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("dec_awready_held", 64'(awready), 64'h0);
      checkOutput("dec_wready_idle", 64'(wready), 64'h1);
      checkOutput("dec_bvalid_idle", 64'(bvalid), 64'h0);
      @(posedge clk);
      #1;
    end
    wvalid = 1'b1;
    wdata  = 32'hDEAD_BEEF;
    wstrb  = 4'hF;
    @(negedge clk);
    checkOutput("dec_wready", 64'(wready), 64'h1);
    @(posedge clk);
    #1;
    wvalid = 1'b0;
    @(negedge clk);
    checkOutput("dec_bvalid_commit_cycle", 64'(bvalid), 64'h0);
    @(negedge clk);
    checkOutput("dec_bvalid_rise", 64'(bvalid), 64'h1);
    checkOutput("dec_slv_reg1", 64'(slv_reg1), 64'hDEAD_BEEF);
    @(posedge clk);
    #1;
    doRead(4'h4, 32'hDEAD_BEEF);

    $display("[TB] write response backpressure");
    exp_b_q.push_back(2'b00);
    exp_pulse_q.push_back(4'b1000);
    applyStimulus(1'b1, 4'hC, 1'b1, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 4'h0, 1'b1);
    @(negedge clk);
    checkOutput("bp_aw_w_ready", 64'({awready, wready}), 64'h3);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    begin : wait_bvalid
      logic got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bvalid) begin got = 1'b1; break; end
      end
      if (!got) reportTimeout("bp_bvalid");
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("bp_b_hold", 64'({bvalid, bresp, awready, wready}), 64'h10);
    end
    @(posedge clk);
    #1;
    bready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("bp_b_released", 64'({bvalid, awready, wready}), 64'h3);
    @(posedge clk);
    #1;

    $display("[TB] read data backpressure");
    exp_r_q.push_back({2'b00, 32'h1234_5678});
    applyStimulus(1'b0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 4'hC, 1'b0);
    @(negedge clk);
    checkOutput("bp_arready", 64'(arready), 64'h1);
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    araddr  = 4'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_r_hold", 64'({rvalid, arready, rdata}), {30'h0, 2'b10, 32'h1234_5678});
      @(posedge clk);
      #1;
    end
    rready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("bp_r_released", 64'({rvalid, arready, rdata}), {30'h0, 2'b01, 32'h1234_5678});
    @(posedge clk);
    #1;

    $display("[TB] reset in the middle of a write");
    applyStimulus(1'b1, 4'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1);
    @(negedge clk);
    checkOutput("mid_awready", 64'(awready), 64'h1);
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("mid_no_bvalid", 64'(bvalid), 64'h0);
    end
    checkOutput("mid_slv_reg3_cleared", 64'(slv_reg3), 64'h0);
    @(posedge clk);
    #1;
    doWrite(4'h0, 32'h0000_0005, 4'hF);
    doRead(4'h0, 32'h0000_0005);
    doRead(4'hC, 32'h0000_0000);

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drained",
                64'(exp_b_q.size() + exp_pulse_q.size() + exp_r_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi4lite_reg_slave.md
# axi4lite_reg_slave

AXI4-Lite slave register file holding four 32-bit read/write control registers. It is the target of the block-design master VIP: it accepts AXI4-Lite writes and reads on the S_AXI port and drives the register contents to user logic. Write-address and write-data channels are accepted independently, byte strobes are honoured, and responses are always OKAY.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register and bits [1:0] are ignored.

- S_AXI_ACLK  in  1  the only clock; all logic is on its rising edge.
- S_AXI_ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00.
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- slv_reg0 .. slv_reg3  out  32 each  current register contents.
- reg_wr_pulse  out  4  one-cycle pulse; bit n is set for the cycle after register n is written.

## Operation
- Storage: four registers. Each register n is mapped at byte address 4n.
- Write path state: aw_held, w_held, BVALID.
  - AWREADY = !aw_held && !BVALID.
  - WREADY = !w_held && !BVALID.
  - On an AW handshake: capture AWADDR[3:2] and set aw_held.
  - On a W handshake: capture WDATA and WSTRB, and set w_held.
  - AW and W may handshake in the same cycle or in either order with any gap.
- Commit: on the first edge where aw_held && w_held:
  - For each byte b with WSTRB[b]=1, reg[addr][8b+7:8b] <= WDATA byte b. Bytes with the strobe low are unchanged.
  - A write with WSTRB=0 still completes, with no data change.
  - Clear aw_held and w_held. Set BVALID. Set reg_wr_pulse[addr] for exactly one cycle.
- Response: BVALID holds until the edge where BREADY=1, then clears. AWREADY and WREADY stay low while BVALID=1, so only one write is outstanding.
- Read path:
  - ARREADY = !RVALID.
  - On an AR handshake, on the same edge: RDATA <= reg[ARADDR[3:2]] and RVALID <= 1.
  - RDATA and RVALID hold stable until the edge where RREADY=1. On that edge RVALID clears; RDATA holds its last value.
- Read and write paths are fully independent and may be active in the same cycle.
- Read/commit collision: when a read samples a register on the same edge that register commits, RDATA returns the pre-write value.
- Reset (asynchronous assert; deassertion is synchronous to S_AXI_ACLK in the system):
  - All registers, RDATA, reg_wr_pulse, aw_held, w_held, BVALID and RVALID go to 0.
  - AWREADY, WREADY and ARREADY go to 1.
  - A transaction in flight when reset asserts is discarded. No response is produced for it, and registers read 0 afterward.

## Timing
- Write latency: BVALID rises on the edge after the later of the AW and W handshakes (one cycle). The register update is visible on slv_regN and to reads in that same cycle.
- Back-to-back writes: at full throughput with BREADY tied high, one write completes every 3 cycles (handshake, commit, response accept).
- Read latency: RVALID rises on the AR handshake edge. With RREADY tied high, one read completes every 2 cycles.
- reg_wr_pulse is registered and aligned with the rising edge of BVALID.
- Handshake rules: no output VALID depends combinationally on a READY input. READY outputs are functions of registered state only.

## Test plan
- Reset: assert S_AXI_ARESET for 200 ns, then release.
  - Required: all slv_regN = 0; AWREADY, WREADY and ARREADY = 1; BVALID and RVALID = 0.
  - Reads of addresses 0x0, 0x4, 0x8 and 0xC return 0x00000000 with RRESP = 0.
- Sequential write/readback: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC with WSTRB = 0xF.
  - Required: each BRESP = 0, and reg_wr_pulse pulses bits 0 to 3 in turn.
  - Reading back returns 1, 2, 3, 4.
- Byte strobes: write 0xAABBCCDD to 0x8 with WSTRB = 0xF, then 0x11223344 with WSTRB = 0x5.
  - Required: reading 0x8 returns 0xAA22CC44.
- Decoupled channels: assert AWVALID for address 0x4; assert WVALID with 0xDEADBEEF three cycles later.
  - Required: AWREADY drops after its handshake and BVALID rises one cycle after the W handshake.
  - Reading 0x4 returns 0xDEADBEEF.
- Backpressure: hold BREADY low for 10 cycles after a write, and RREADY low for 10 cycles after a read.
  - Required: BVALID, RVALID and RDATA stay stable throughout.
  - AWREADY, WREADY and ARREADY stay 0 throughout; each clears one edge after its READY input is raised.
- Reset mid-transaction: assert reset for one cycle after an AW handshake but before W.
  - Required: no BVALID is produced.
  - A subsequent full write of 0x5 to 0x0 completes normally, and reading 0x0 returns 0x5.
